// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared op encoding and widths for the logic unit.
// Imported by logic_core_n and logic_unit_pipe.
package logic_unit_pkg;
  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_NAND  = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;
endpackage

// File: rtl/logic_core_n.sv
// logic_core_n: combinational N-bit bitwise op mux.
// Sits between stage 1 and stage 2 of logic_unit_pipe.
module logic_core_n
  import logic_unit_pkg::*;
#(
  parameter int N = 4
) (
  input  op_e          op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~(a | b);
      OP_NAND:  y = ~(a & b);
      OP_XNOR:  y = ~(a ^ b);
      OP_NOTA:  y = ~a;
      OP_PASSB: y = b;
    endcase
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with Z/N flags.
// Define LOGIC_UNIT_PARITY_EN to add a registered parity flag (flag_p).
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    result,
  output logic            flag_z,
`ifdef LOGIC_UNIT_PARITY_EN
  output logic            flag_p,
`endif
  output logic            flag_n
);
  logic         s1_valid;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  op_e          s1_op;
  logic         s2_valid;
  logic [N-1:0] core_y;
  logic         s1_adv;
  logic         s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic_core_n #(.N(N)) u_core (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .y  (core_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
      s2_valid <= 1'b0;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= a;
          s1_b  <= b;
          s1_op <= op_e'(op);
        end
      end
      // a bubble clears s2_valid but leaves the held data alone
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= core_y;
          flag_z <= ~|core_y;
          flag_n <= core_y[N-1];
        end
      end
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_p <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      flag_p <= ^core_y;
    end
  end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized scoreboard bench for logic_unit_pipe.
// Main DUT is N=4; a second N=8 instance covers width and parity.
module tb_logic_unit_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] result;
  logic       flag_z;
  logic       flag_n;

  logic       iv8 = 1'b0;
  logic       ir8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [2:0] op8 = '0;
  logic       ov8;
  logic [7:0] r8;
  logic       z8;
  logic       n8;
`ifdef LOGIC_UNIT_PARITY_EN
  logic       p4;
  logic       p8;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [5:0] exp_q[$];
  int         acc_q[$];

  always #5 clk = ~clk;

  logic_unit_pipe #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
`ifdef LOGIC_UNIT_PARITY_EN
    .flag_p    (p4),
`endif
    .flag_n    (flag_n)
  );

  logic_unit_pipe #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .op        (op8),
    .out_valid (ov8),
    .out_ready (1'b1),
    .result    (r8),
    .flag_z    (z8),
`ifdef LOGIC_UNIT_PARITY_EN
    .flag_p    (p8),
`endif
    .flag_n    (n8)
  );

  // each op as a truth table indexed by {a_bit, b_bit}
  function automatic logic [7:0] ref_f(input logic [2:0] o,
                                       input logic [7:0] x,
                                       input logic [7:0] y);
    logic [3:0] tt;
    logic [7:0] r;
    case (o)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0111;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1010;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  function automatic logic [5:0] ref4(input logic [2:0] o,
                                      input logic [3:0] x,
                                      input logic [3:0] y);
    logic [7:0] r;
    r = ref_f(o, {4'h0, x}, {4'h0, y});
    return {r[3:0], r[3:0] == 4'h0, r[3]};
  endfunction

  // one cycle: drive, observe before the edge, update the scoreboard
  task automatic step(input logic iv, input logic [2:0] o,
                      input logic [3:0] x, input logic [3:0] y,
                      input logic ordy,
                      output logic ov, output logic [5:0] got,
                      output logic [5:0] want, output logic have,
                      output int lat);
    logic acc;
    logic drn;
    in_valid = iv;
    op = o;
    a = x;
    b = y;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    ov = out_valid;
    got = {result, flag_z, flag_n};
    have = exp_q.size() > 0;
    want = have ? exp_q[0] : 6'h0;
    lat = have ? cyc - acc_q[0] : -1;
    @(posedge clk);
    if (drn && have) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back(ref4(o, x, y));
      acc_q.push_back(cyc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 4'hF;
    b = 4'hF;
    op = 3'd1;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({out_valid, result, flag_z, flag_n} !== 7'h0) begin
        n_fail++;
        $display("FAIL reset_state: got %b want 0000000",
                 {out_valid, result, flag_z, flag_n});
      end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic test_stream();
    logic [2:0] ops[4] = '{3'd1, 3'd0, 3'd2, 3'd3};
    logic [3:0] as[4] = '{4'b0111, 4'b1111, 4'b1010, 4'b0000};
    logic [3:0] bs[4] = '{4'b1000, 4'b0000, 4'b1010, 4'b0000};
    logic [5:0] fixed[4] = '{6'b1111_0_1, 6'b0000_1_0,
                             6'b0000_1_0, 6'b1111_0_1};
    logic ov, have;
    logic [5:0] got, want;
    int lat;
    int k = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) step(1'b1, ops[i], as[i], bs[i], 1'b1,
                      ov, got, want, have, lat);
      else step(1'b0, 3'd0, 4'h0, 4'h0, 1'b1, ov, got, want, have, lat);
      if (ov) begin
        n_checks++;
        if (k > 3 || got !== fixed[k] || lat != 2) begin
          n_fail++;
          $display("FAIL stream_beat%0d: got %b lat %0d want %b lat 2",
                   k, got, lat, (k < 4) ? fixed[k & 3] : 6'h0);
        end
        k++;
      end
    end
    n_checks++;
    if (k != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got %0d beats want 4", k);
    end
  endtask

  task automatic test_backpressure();
    logic exp_rdy[8] = '{1'b1, 1'b1, 1'b0, 1'b0,
                         1'b1, 1'b1, 1'b1, 1'b1};
    logic ov, have;
    logic [5:0] got, want;
    int lat;
    for (int i = 0; i < 14; i++) begin
      logic iv;
      logic ordy;
      iv = (i < 8);
      ordy = (i >= 4);
      in_valid = iv;
      out_ready = ordy;
      #1;
      if (i < 8) begin
        n_checks++;
        if (in_ready !== exp_rdy[i]) begin
          n_fail++;
          $display("FAIL bp_in_ready%0d: got %b want %b",
                   i, in_ready, exp_rdy[i]);
        end
      end
      step(iv, 3'($urandom_range(7)), 4'($urandom), 4'($urandom),
           ordy, ov, got, want, have, lat);
      if (ov) begin
        n_checks++;
        if (!have || got !== want) begin
          n_fail++;
          $display("FAIL bp_data%0d: got %b want %b have %b",
                   i, got, want, have);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: %0d beats left, out_valid %b want 0",
               exp_q.size(), out_valid);
    end
  endtask

  task automatic test_random();
    logic ov, have;
    logic [5:0] got, want;
    int lat;
    int errs = 0;
    for (int i = 0; i < 520; i++) begin
      logic iv;
      iv = (i < 500) && ($urandom_range(3) != 0);
      step(iv, 3'($urandom_range(7)), 4'($urandom), 4'($urandom),
           (i >= 500) || ($urandom_range(2) != 0),
           ov, got, want, have, lat);
      if (ov) begin
        n_checks++;
        if (!have || got !== want) begin
          n_fail++;
          errs++;
          if (errs < 10)
            $display("FAIL rand_data%0d: got %b want %b have %b",
                     i, got, want, have);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    logic ov, have;
    logic [5:0] got, want;
    int lat;
    for (int i = 0; i < 3; i++)
      step(1'b1, 3'd6, 4'h0, 4'h0, 1'b0, ov, got, want, have, lat);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fill: out_valid %b in_ready %b want 1 0",
               out_valid, in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    n_checks++;
    if ({out_valid, result, flag_z, flag_n} !== 7'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want 0000000",
               {out_valid, result, flag_z, flag_n});
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'd0, 4'h0, 4'h0, 1'b1, ov, got, want, have, lat);
      n_checks++;
      if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_ghost%0d: out_valid %b want 0", i, ov);
      end
    end
  endtask

  task automatic test_width();
    logic [2:0] ops[2] = '{3'd4, 3'd6};
    logic [7:0] xs[2] = '{8'hF0, 8'h00};
    logic [7:0] ys[2] = '{8'h3C, 8'h5A};
    logic [10:0] fixed[2] = '{{8'hCF, 1'b0, 1'b1, 1'b0},
                              {8'hFF, 1'b0, 1'b1, 1'b0}};
    for (int t = 0; t < 2; t++) begin
      logic p;
      int w;
      iv8 = 1'b1;
      op8 = ops[t];
      a8 = xs[t];
      b8 = ys[t];
      @(posedge clk);
      @(negedge clk);
      iv8 = 1'b0;
      w = 0;
      while (!ov8 && w < 5) begin
        @(negedge clk);
        w++;
      end
`ifdef LOGIC_UNIT_PARITY_EN
      p = p8;
`else
      p = ^r8;
`endif
      n_checks++;
      if (!ov8 || {r8, z8, n8, p} !== fixed[t] ||
          r8 !== ref_f(ops[t], xs[t], ys[t])) begin
        n_fail++;
        $display("FAIL width%0d: valid %b got %h z%b n%b p%b want %h",
                 t, ov8, r8, z8, n8, p, fixed[t]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_width();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
